// File: rtl/fm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fm_pkg
//  Purpose  : Shared types and constants for the frequency meter sequencer,
//             counter bank and result multiplexer.
//  Contents : fm_state_e   - measurement sequencer states
//             SEL_*        - channel select codes {K1_level, K2_level}
//             RESULT_W     - counter result width
//             fm_max3()    - largest of three values (for counter sizing)
//  Revision : 1.0 - initial release
// ============================================================================
package fm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_GATE   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LATCH  = 3'd4
  } fm_state_e;

  localparam logic [1:0] SEL_NONE = 2'd3;
  localparam logic [1:0] SEL_K1   = 2'd1;
  localparam logic [1:0] SEL_K2   = 2'd2;
  localparam logic [1:0] SEL_BOTH = 2'd0;

  localparam int unsigned RESULT_W = 32;

  function automatic int unsigned fm_max3(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : key_debounce
//  Purpose  : One front-panel key: 2-flop synchronizer followed (when
//             FM_DEBOUNCE_EN is defined) by a stability filter that accepts a
//             new level only after it has held for DEB_CYCLES clocks.
//             Without FM_DEBOUNCE_EN the synchronized level is passed through.
//  Ports    : clk     - system clock
//             rst_n   - asynchronous active-low reset
//             key_raw - raw asynchronous key input (active-low)
//             level   - accepted key level (1 = released)
//  Macro    : FM_DEBOUNCE_EN
//  Revision : 1.0 - initial release
// ============================================================================
module key_debounce
  import fm_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic level
);

  // r_sync[0] is the metastability stage; only r_sync[1] is used downstream.
  logic [1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], key_raw};
  end

`ifdef FM_DEBOUNCE_EN
  localparam int c_cnt_w = $clog2(DEB_CYCLES) + 1;
  localparam logic [c_cnt_w-1:0] c_deb = c_cnt_w'(DEB_CYCLES);
  localparam logic [c_cnt_w-1:0] c_one = c_cnt_w'(1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_accepted;
  logic [c_cnt_w-1:0] w_remaining;

  // A count of 0 means "no change pending"; the first differing cycle acts
  // as if the counter had just been loaded with DEB_CYCLES.
  assign w_remaining = (r_cnt == '0) ? c_deb : r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_accepted <= 1'b1;
    end else if (r_sync[1] == r_accepted) begin
      r_cnt <= '0;                      // bounce back: restart the filter
    end else if (w_remaining == c_one) begin
      r_accepted <= r_sync[1];
      r_cnt      <= '0;
    end else begin
      r_cnt <= w_remaining - c_one;
    end
  end

  assign level = r_accepted;
`else
  logic w_unused_deb;
  assign w_unused_deb = ^DEB_CYCLES;
  assign level        = r_sync[1];
`endif

endmodule
`default_nettype wire

// File: rtl/freq_meas_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : freq_meas_ctrl
//  Purpose  : Measurement sequencer for the digital frequency meter. Debounces
//             K1/K2 into the channel select and runs the free-running
//             clear / gate / settle / latch cycle for the counter bank. Any
//             select change outside IDLE aborts the window and restarts at
//             CLEAR.
//  Ports    : CLK     - system clock
//             RST_N   - asynchronous active-low reset
//             K1, K2  - raw active-low keys
//             SEL     - debounced select {K1_level, K2_level}
//             CNT_CLR - synchronous clear to the counters
//             CNT_EN  - gate enable to the counters
//             LATCH   - one-cycle display capture strobe
//             VALID   - latched result belongs to the current SEL
//  Macro    : FM_DEBOUNCE_EN (enables the key stability filter)
//  Revision : 1.0 - initial release
// ============================================================================
module freq_meas_ctrl
  import fm_pkg::*;
#(
  parameter int unsigned GATE_CYCLES   = 50_000_000,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned DEB_CYCLES    = 1_000_000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       K1,
  input  logic       K2,
  output logic [1:0] SEL,
  output logic       CNT_CLR,
  output logic       CNT_EN,
  output logic       LATCH,
  output logic       VALID
);

  localparam int unsigned c_cnt_max = fm_max3(GATE_CYCLES, SETTLE_CYCLES, DEB_CYCLES);
  localparam int          c_cnt_w   = $clog2(c_cnt_max) + 1;
  localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_gate   = c_cnt_w'(GATE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_settle = c_cnt_w'(SETTLE_CYCLES);

  logic               w_k1_level;
  logic               w_k2_level;
  logic [1:0]         w_sel_next;
  logic               w_abort;
  fm_state_e          r_state;
  fm_state_e          w_next_state;
  logic               r_idle_done;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_next;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_k1 (
    .clk     (CLK),
    .rst_n   (RST_N),
    .key_raw (K1),
    .level   (w_k1_level)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_k2 (
    .clk     (CLK),
    .rst_n   (RST_N),
    .key_raw (K2),
    .level   (w_k2_level)
  );

  assign w_sel_next = {w_k1_level, w_k2_level};
  // The abort is taken on the same edge that updates SEL, so the counters
  // never see an enable cycle belonging to the new selection's stale window.
  assign w_abort    = (w_sel_next != SEL) && (r_state != ST_IDLE);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (r_idle_done)    w_next_state = ST_CLEAR;
      ST_CLEAR:                      w_next_state = ST_GATE;
      ST_GATE:   if (r_cnt <= c_one) w_next_state = ST_SETTLE;
      ST_SETTLE: if (r_cnt <= c_one) w_next_state = ST_LATCH;
      ST_LATCH:                      w_next_state = ST_CLEAR;
      default:                       w_next_state = ST_IDLE;
    endcase
    if (w_abort) w_next_state = ST_CLEAR;

    // Counter reloads on entry to a timed state and counts down to 1.
    w_cnt_next = '0;
    case (w_next_state)
      ST_GATE:   w_cnt_next = (r_state == ST_GATE)   ? r_cnt - c_one : c_gate;
      ST_SETTLE: w_cnt_next = (r_state == ST_SETTLE) ? r_cnt - c_one : c_settle;
      default:   w_cnt_next = '0;
    endcase
  end

  // Outputs are registered from the next-state decode so they are aligned
  // with the state register and glitch-free.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_idle_done <= 1'b0;
      r_cnt       <= '0;
      SEL         <= SEL_NONE;
      CNT_CLR     <= 1'b0;
      CNT_EN      <= 1'b0;
      LATCH       <= 1'b0;
      VALID       <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_idle_done <= 1'b1;
      r_cnt       <= w_cnt_next;
      SEL         <= w_sel_next;
      CNT_CLR     <= (w_next_state == ST_CLEAR);
      CNT_EN      <= (w_next_state == ST_GATE);
      LATCH       <= (w_next_state == ST_LATCH);
      if (w_abort)                  VALID <= 1'b0;
      else if (r_state == ST_LATCH) VALID <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_freq_meas_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_freq_meas_ctrl
//  Purpose  : Directed self-checking bench for freq_meas_ctrl with
//             GATE_CYCLES=10, SETTLE_CYCLES=2, DEB_CYCLES=4. Expectations
//             follow the FM_DEBOUNCE_EN setting of the build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_freq_meas_ctrl;
  import fm_pkg::*;

  localparam int G = 10;
  localparam int S = 2;
  localparam int D = 4;
  localparam int P = 1 + G + S + 1;     // measurement period
`ifdef FM_DEBOUNCE_EN
  localparam int LAT = 2 + D + 1;       // key edge to SEL
`else
  localparam int LAT = 3;
`endif

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b0;
  logic       K1    = 1'b1;
  logic       K2    = 1'b1;
  logic [1:0] SEL;
  logic       CNT_CLR, CNT_EN, LATCH, VALID;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  freq_meas_ctrl #(
    .GATE_CYCLES   (G),
    .SETTLE_CYCLES (S),
    .DEB_CYCLES    (D)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .K1      (K1),
    .K2      (K2),
    .SEL     (SEL),
    .CNT_CLR (CNT_CLR),
    .CNT_EN  (CNT_EN),
    .LATCH   (LATCH),
    .VALID   (VALID)
  );

  always #5 CLK = ~CLK;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Advance one clock; sample point is the following falling edge.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
  endtask

  // {CNT_CLR, CNT_EN, LATCH, VALID} for cycle c of a schedule whose CLEAR
  // cycle is b. VALID is v0 until the first LATCH of that schedule has passed.
  function automatic logic [3:0] exp_ctrl(input int c, input int b, input bit v0);
    int d;
    bit v;
    d = (c - b) % P;
    v = v0 || ((c - b) >= P);
    return {d == 0, (d >= 1) && (d <= G), d == (G + S + 1), v};
  endfunction

  task automatic track(input int last, input int b, input bit v0, input logic [1:0] sel);
    while (cyc < last) begin
      step();
      check_value("ctrl_clr_en_latch_valid", {28'd0, CNT_CLR, CNT_EN, LATCH, VALID},
                  {28'd0, exp_ctrl(cyc, b, v0)});
      check_value("sel", {30'd0, SEL}, {30'd0, sel});
    end
  endtask

  int b;
  int b3;
  int b4;
  int t;

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_value("reset_sel", {30'd0, SEL}, {30'd0, SEL_NONE});
    check_value("reset_ctrl", {28'd0, CNT_CLR, CNT_EN, LATCH, VALID}, 32'd0);
    RST_N = 1'b1;
    cyc   = 0;

    // ---------------- startup sequence ----------------
    step();
    check_value("idle_ctrl", {28'd0, CNT_CLR, CNT_EN, LATCH, VALID}, 32'd0);
    track(16, 2, 1'b0, SEL_NONE);       // CLR@2, EN 3-12, LATCH@15, VALID/CLR@16

    // ---------------- K1 press aborts mid-gate ----------------
    t  = cyc;
    K1 = 1'b0;
    track(t + LAT - 1, 2, 1'b0, SEL_NONE);
    b = t + LAT;                        // SEL change edge starts CLEAR, VALID drops
    track(b + P, b, 1'b0, SEL_K1);      // LATCH at b+13, VALID back at b+14

`ifdef FM_DEBOUNCE_EN
    // ---------------- K2 bounce: rejected, no abort ----------------
    for (int i = 0; i < 30; i++) begin
      K2 = (((i / 3) % 2) == 0) ? 1'b0 : 1'b1;
      track(cyc + 1, b, 1'b1, SEL_K1);
    end
    K2 = 1'b1;
    track(cyc + LAT + 2, b, 1'b1, SEL_K1);
`else
    // ---------------- 1-cycle K2 glitch: two aborts ----------------
    t  = cyc;
    K2 = 1'b0;
    track(t + 1, b, 1'b1, SEL_K1);
    K2 = 1'b1;
    track(t + LAT - 1, b, 1'b1, SEL_K1);
    step();
    check_value("glitch_sel", {30'd0, SEL}, {30'd0, SEL_BOTH});
    check_value("glitch_ctrl", {28'd0, CNT_CLR, CNT_EN, LATCH, VALID}, 32'h8);
    b = t + LAT + 1;
    track(b + P, b, 1'b0, SEL_K1);
`endif

    // ---------------- release K1, then both keys hit the last GATE cycle ----
    t  = cyc;
    K1 = 1'b1;
    track(t + LAT - 1, b, 1'b1, SEL_K1);
    b3 = t + LAT;
    track(b3 + 11 - LAT, b3, 1'b0, SEL_NONE);
    K1 = 1'b0;
    K2 = 1'b0;
    track(b3 + G, b3, 1'b0, SEL_NONE);  // last GATE cycle still enabled
    b4 = b3 + G + 1;                    // abort replaces SETTLE with CLEAR
    track(b4 + P, b4, 1'b0, SEL_BOTH);

    // ---------------- async reset in the 5th GATE cycle ----------------
    track(b4 + P + 5, b4, 1'b0, SEL_BOTH);
    RST_N = 1'b0;
    #1;
    check_value("async_rst_en", {31'd0, CNT_EN}, 32'd0);
    check_value("async_rst_valid", {31'd0, VALID}, 32'd0);
    check_value("async_rst_sel", {30'd0, SEL}, {30'd0, SEL_NONE});
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    cyc   = 0;
    step();
    check_value("restart_idle", {28'd0, CNT_CLR, CNT_EN, LATCH, VALID}, 32'd0);
    step();
    check_value("restart_clr", {28'd0, CNT_CLR, CNT_EN, LATCH, VALID}, 32'h8);
    check_value("restart_sel", {30'd0, SEL}, {30'd0, SEL_NONE});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
